// File: rtl/demux_pkg.sv
// Shared types and constants for the lane-collect demux: state encoding,
// default geometry and lane slice placement.
package demux_pkg;

    localparam int NR_LANE  = 4;
    localparam int LANE_LEN = 2;
    localparam int KEY_W    = $clog2(NR_LANE);
    localparam int DATA_W   = NR_LANE * LANE_LEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_e;

    // Lane k occupies out_data[lane_lo(k)+len-1 : lane_lo(k)].
    function automatic int lane_lo(input int lane, input int len);
        return lane * len;
    endfunction

endpackage

// File: rtl/dec24.sv
// One-hot lane decoder with enable; drives both data-write and mask-set strobes.
module dec24 #(
    parameter int N  = demux_pkg::NR_LANE,
    localparam int KW = $clog2(N)
) (
    input  logic          en_i,
    input  logic [KW-1:0] sel_i,
    output logic [N-1:0]  oh_o
);

    always_comb begin
        oh_o = '0;
        if (en_i) oh_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/demux24_collect.sv
// Collects keyed lane writes into one frame; delivers it once every lane
// has been written, then starts a fresh frame.
module demux24_collect #(
    parameter int  NR_LANE  = demux_pkg::NR_LANE,
    parameter int  LANE_LEN = demux_pkg::LANE_LEN,
    localparam int KW       = $clog2(NR_LANE),
    localparam int DW       = NR_LANE * LANE_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KW-1:0]       in_key,
    input  logic [LANE_LEN-1:0] in_data,
    input  logic                clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic                dup_err,
    output logic [7:0]          frame_cnt
);
    import demux_pkg::*;

    state_e              state_q, state_d;
    logic [NR_LANE-1:0]  mask_q, mask_d, lane_oh;
    logic [DW-1:0]       data_q, data_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                dup_q, dup_d;
    logic                rdy_q;
    logic                acc, wr_en;

    // rdy_q keeps in_ready low while in reset and releases it one edge later.
    assign in_ready  = rdy_q && (state_q != FULL);
    assign acc       = in_valid && in_ready;
    assign wr_en     = acc && !clr;
    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign dup_err   = dup_q;
    assign frame_cnt = cnt_q;

    dec24 #(.N(NR_LANE)) u_dec (
        .en_i (wr_en),
        .sel_i(in_key),
        .oh_o (lane_oh)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dup_d   = 1'b0;
        case (state_q)
            FULL: begin
                if (out_ready) begin
                    state_d = IDLE;
                    mask_d  = '0;
                    data_d  = '0;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                if (clr) begin
                    state_d = IDLE;
                    mask_d  = '0;
                    data_d  = '0;
                end else if (wr_en) begin
                    mask_d = mask_q | lane_oh;
                    dup_d  = |(mask_q & lane_oh);
                    for (int i = 0; i < NR_LANE; i++)
                        if (lane_oh[i]) data_d[lane_lo(i, LANE_LEN) +: LANE_LEN] = in_data;
                    // A rewrite never sets a new bit, so it can never complete the mask.
                    state_d = (&mask_d) ? FULL : FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dup_q   <= dup_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: doc/demux24_collect.md
DEMUX24_COLLECT -- requirements
Module: demux24_collect

Interface
REQ-001 Param NR_LANE, default 4: number of lanes; key width = log2(NR_LANE).
REQ-002 Param LANE_LEN, default 2: data bits per lane; out_data width = NR_LANE*LANE_LEN.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer offers one lane write.
REQ-006 in_ready  output  1  block accepts the lane write this cycle.
REQ-007 in_key  input  2  lane select.
REQ-008 in_data  input  2  lane payload.
REQ-009 clr  input  1  synchronous flush of the partial frame.
REQ-010 out_valid  output  1  assembled 8-bit frame available.
REQ-011 out_ready  input  1  consumer takes the frame.
REQ-012 out_data  output  8  assembled frame.
REQ-013 dup_err  output  1  one-cycle pulse: a lane was rewritten before frame completion.
REQ-014 frame_cnt  output  8  count of frames delivered.

Function
REQ-015 Lane map SHALL be: key 00 -> out_data[1:0], 01 -> [3:2], 10 -> [5:4], 11 -> [7:6].
REQ-016 Input handshake SHALL be in_valid & in_ready; output handshake SHALL be out_valid & out_ready.
REQ-017 FSM states SHALL be IDLE (mask 0000), FILL (mask partial), FULL (mask 1111).
REQ-018 In IDLE and FILL, in_ready SHALL be 1; in FULL, in_ready SHALL be 0.
REQ-019 An accepted write SHALL store in_data into the keyed lane and set that lane's mask bit at the next edge.
REQ-020 Transitions: IDLE->FILL on the first accept; FILL->FULL on the accept that completes the mask; FULL->IDLE on output handshake.
REQ-021 out_valid SHALL be 1 exactly in FULL; latency from the completing accept to out_valid SHALL be 1 cycle.
REQ-022 out_data SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-023 On output handshake, the data register and mask SHALL clear to 0, and frame_cnt SHALL increment by 1, wrapping 255->0.
REQ-024 An accept to a lane whose mask bit is already set SHALL overwrite the data, leave the mask unchanged, and pulse dup_err for the following cycle.
REQ-025 clr=1 in IDLE or FILL SHALL clear data and mask and go to IDLE; a simultaneous accept SHALL be discarded (clr wins), with no dup_err.
REQ-026 clr=1 in FULL SHALL be ignored; the frame SHALL still be delivered.
REQ-027 A completing accept of a duplicate lane is impossible by construction; dup_err SHALL never coincide with FILL->FULL.
REQ-028 frame_cnt SHALL NOT change on clr or dup_err.

Reset
REQ-029 While rst_n=0: state IDLE, mask 0, out_data 0, out_valid 0, in_ready 0, dup_err 0, frame_cnt 0.
REQ-030 Reset asserted mid-frame or in FULL SHALL discard the frame without incrementing frame_cnt.
REQ-031 in_ready SHALL rise in the first cycle after rst_n deasserts.

Structure
REQ-032 Shared package demux_pkg SHALL hold the state enum (IDLE/FILL/FULL), NR_LANE, LANE_LEN and the lane-slice constants.
REQ-033 One sub-module dec24 SHALL provide the 2-to-4 one-hot lane decoder with enable, used for the data-write and mask-set strobes.

Verification
REQ-034 Write keys 00,01,10,11 with data 01,10,11,00 on consecutive cycles, out_ready=1 -> out_valid one cycle after the 4th accept, out_data=8'h39, frame_cnt 0->1.
REQ-035 Fill the frame with out_ready=0 for 5 cycles -> out_valid held, out_data stable, in_ready=0; an in_valid pulse is not accepted; release -> IDLE.
REQ-036 Write key 01 data 10, then key 01 data 11 -> dup_err=1 for one cycle, lane [3:2]=11, still FILL.
REQ-037 Write keys 00 and 01, then clr together with key 10 -> IDLE, mask 0, no dup_err; the next full frame assembles only new data.
REQ-038 Deliver 256 frames -> frame_cnt wraps to 0; assert rst_n=0 mid-frame -> all outputs 0 asynchronously, frame_cnt unchanged from the reset value 0.
